// File: rtl/rx_slot_sched.sv
// Frame-level RX slot scheduler: walks a programmable slot table per frame,
// issuing one window start per slot with watchdog, guard gap and abort handling.
module rx_slot_sched #(
  parameter int CNT_W = 32,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_window,
  input  logic [IDX_W:0]   cfg_nslot,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [CNT_W-1:0] cfg_wd,
  input  logic             frame_trig,
  input  logic             abort,
  input  logic             win_busy,
  input  logic             win_done,
  output logic             win_start_pulse,
  output logic [CNT_W-1:0] win_delay,
  output logic [CNT_W-1:0] win_window,
  output logic [IDX_W-1:0] slot_idx,
  output logic             frame_busy,
  output logic             frame_done,
  output logic             frame_abort,
  output logic             err_timeout,
  output logic             trig_overrun
);

  localparam int NSLOT = 2 ** IDX_W;
  localparam logic [IDX_W:0]   NSLOT_V = (IDX_W + 1)'(NSLOT);
  localparam logic [IDX_W:0]   N_ONE   = (IDX_W + 1)'(1);
  localparam logic [IDX_W-1:0] I_ONE   = IDX_W'(1);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tbl_delay_q  [NSLOT];
  logic [CNT_W-1:0] tbl_delay_d  [NSLOT];
  logic [CNT_W-1:0] tbl_window_q [NSLOT];
  logic [CNT_W-1:0] tbl_window_d [NSLOT];
  logic [IDX_W:0]   nslot_q, nslot_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             start_q, start_d;
  logic [CNT_W-1:0] win_delay_q, win_delay_d;
  logic [CNT_W-1:0] win_window_q, win_window_d;
  logic [IDX_W-1:0] slot_idx_q, slot_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic             tmo_q, tmo_d;
  logic             ovr_q, ovr_d;

  logic [IDX_W:0]   nslot_clamp;
  logic             last_slot;
  logic             do_issue;
  logic [IDX_W-1:0] issue_idx;

  assign nslot_clamp = (cfg_nslot > NSLOT_V) ? NSLOT_V : cfg_nslot;
  assign last_slot   = ({1'b0, slot_idx_q} == (nslot_q - N_ONE));

  always_comb begin
    tbl_delay_d  = tbl_delay_q;
    tbl_window_d = tbl_window_q;
    state_d      = state_q;
    nslot_d      = nslot_q;
    gap_d        = gap_q;
    wd_d         = wd_q;
    wd_cnt_d     = wd_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    start_d      = 1'b0;
    win_delay_d  = win_delay_q;
    win_window_d = win_window_q;
    slot_idx_d   = slot_idx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    abort_d      = 1'b0;
    tmo_d        = 1'b0;
    ovr_d        = 1'b0;
    do_issue     = 1'b0;
    issue_idx    = slot_idx_q + I_ONE;

    if (cfg_we) begin
      tbl_delay_d[cfg_addr]  = cfg_delay;
      tbl_window_d[cfg_addr] = cfg_window;
    end

    if (state_q == IDLE) begin
      if (frame_trig && !abort) begin
        if (win_busy) begin
          ovr_d = 1'b1;
        end else begin
          nslot_d = nslot_clamp;
          gap_d   = cfg_gap;
          wd_d    = cfg_wd;
          if (nslot_clamp == '0) begin
            done_d = 1'b1;
          end else begin
            do_issue  = 1'b1;
            issue_idx = '0;
          end
        end
      end
    end else if (abort) begin
      // Abort beats everything in an active frame; the running window is left alone
      abort_d = 1'b1;
      busy_d  = 1'b0;
      state_d = IDLE;
      ovr_d   = frame_trig;
    end else begin
      ovr_d = frame_trig;
      if (state_q == WAIT) begin
        if (win_done) begin
          if (last_slot) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else if (gap_q == '0) begin
            do_issue = 1'b1;
          end else begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end
        end else if ((wd_q != '0) && (wd_cnt_q == (wd_q - C_ONE))) begin
          tmo_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + C_ONE;
        end
      end else begin
        if (gap_cnt_q == (gap_q - C_ONE)) begin
          do_issue = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + C_ONE;
        end
      end
    end

    // Issue uses pre-edge table contents, so a same-edge write is not seen
    if (do_issue) begin
      state_d      = WAIT;
      start_d      = 1'b1;
      win_delay_d  = tbl_delay_q[issue_idx];
      win_window_d = tbl_window_q[issue_idx];
      slot_idx_d   = issue_idx;
      wd_cnt_d     = '0;
      busy_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      for (int i = 0; i < NSLOT; i++) begin
        tbl_delay_q[i]  <= '0;
        tbl_window_q[i] <= '0;
      end
      nslot_q      <= '0;
      gap_q        <= '0;
      wd_q         <= '0;
      wd_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      start_q      <= 1'b0;
      win_delay_q  <= '0;
      win_window_q <= '0;
      slot_idx_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
      tmo_q        <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tbl_delay_q  <= tbl_delay_d;
      tbl_window_q <= tbl_window_d;
      nslot_q      <= nslot_d;
      gap_q        <= gap_d;
      wd_q         <= wd_d;
      wd_cnt_q     <= wd_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      start_q      <= start_d;
      win_delay_q  <= win_delay_d;
      win_window_q <= win_window_d;
      slot_idx_q   <= slot_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
      tmo_q        <= tmo_d;
      ovr_q        <= ovr_d;
    end
  end

  assign win_start_pulse = start_q;
  assign win_delay       = win_delay_q;
  assign win_window      = win_window_q;
  assign slot_idx        = slot_idx_q;
  assign frame_busy      = busy_q;
  assign frame_done      = done_q;
  assign frame_abort     = abort_q;
  assign err_timeout     = tmo_q;
  assign trig_overrun    = ovr_q;

endmodule

// File: tb/tb_rx_slot_sched.sv
// Directed self-checking bench for rx_slot_sched; the window controller is
// emulated by driving win_busy/win_done directly from the stimulus sequence.
module tb_rx_slot_sched;

  localparam int CNT_W = 32;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_window;
  logic [IDX_W:0]   cfg_nslot;
  logic [CNT_W-1:0] cfg_gap;
  logic [CNT_W-1:0] cfg_wd;
  logic             frame_trig;
  logic             abort;
  logic             win_busy;
  logic             win_done;
  logic             win_start_pulse;
  logic [CNT_W-1:0] win_delay;
  logic [CNT_W-1:0] win_window;
  logic [IDX_W-1:0] slot_idx;
  logic             frame_busy;
  logic             frame_done;
  logic             frame_abort;
  logic             err_timeout;
  logic             trig_overrun;

  int checks = 0;
  int errors = 0;
  int startCount = 0;
  int base;

  rx_slot_sched #(.CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_delay       (cfg_delay),
    .cfg_window      (cfg_window),
    .cfg_nslot       (cfg_nslot),
    .cfg_gap         (cfg_gap),
    .cfg_wd          (cfg_wd),
    .frame_trig      (frame_trig),
    .abort           (abort),
    .win_busy        (win_busy),
    .win_done        (win_done),
    .win_start_pulse (win_start_pulse),
    .win_delay       (win_delay),
    .win_window      (win_window),
    .slot_idx        (slot_idx),
    .frame_busy      (frame_busy),
    .frame_done      (frame_done),
    .frame_abort     (frame_abort),
    .err_timeout     (err_timeout),
    .trig_overrun    (trig_overrun)
  );

  always #5 clk = ~clk;

  // Start pulses last a full cycle, so a negedge sample counts each exactly once
  always @(negedge clk) begin
    if (win_start_pulse) startCount++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given frame-side inputs; pulse inputs drop after the edge
  task automatic applyStimulus(input logic trig, input logic abrt, input logic busy, input logic done);
    frame_trig = trig;
    abort      = abrt;
    win_busy   = busy;
    win_done   = done;
    @(posedge clk);
    #1;
    frame_trig = 1'b0;
    abort      = 1'b0;
    win_done   = 1'b0;
  endtask

  task automatic cfgWrite(input logic [IDX_W-1:0] a, input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] w);
    cfg_we     = 1'b1;
    cfg_addr   = a;
    cfg_delay  = d;
    cfg_window = w;
    applyStimulus(1'b0, 1'b0, win_busy, 1'b0);
    cfg_we     = 1'b0;
  endtask

  initial begin
    logic [CNT_W-1:0] expDelay [4];
    expDelay[0] = 3; expDelay[1] = 0; expDelay[2] = 7; expDelay[3] = 9;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_delay = '0; cfg_window = '0;
    cfg_nslot = '0; cfg_gap = '0; cfg_wd = '0;
    frame_trig = 1'b0; abort = 1'b0; win_busy = 1'b0; win_done = 1'b0;
    #2;
    checkOutput("rst_start", win_start_pulse, 0);
    checkOutput("rst_busy", frame_busy, 0);
    checkOutput("rst_delay", win_delay, 0);
    checkOutput("rst_done", frame_done, 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-slot frame, no gap, no watchdog
    cfgWrite(0, 3, 5);
    cfgWrite(1, 0, 2);
    cfg_nslot = 2; cfg_gap = 0; cfg_wd = 0;
    applyStimulus(1, 0, 0, 0);
    checkOutput("t1_start0", win_start_pulse, 1);
    checkOutput("t1_delay0", win_delay, 3);
    checkOutput("t1_window0", win_window, 5);
    checkOutput("t1_idx0", slot_idx, 0);
    checkOutput("t1_busy0", frame_busy, 1);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("t1_nostart", win_start_pulse, 0);
    checkOutput("t1_busy_mid", frame_busy, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t1_start1", win_start_pulse, 1);
    checkOutput("t1_delay1", win_delay, 0);
    checkOutput("t1_window1", win_window, 2);
    checkOutput("t1_idx1", slot_idx, 1);
    checkOutput("t1_nodone", frame_done, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t1_done", frame_done, 1);
    checkOutput("t1_busy_end", frame_busy, 0);
    checkOutput("t1_end_nostart", win_start_pulse, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t1_done_pulse", frame_done, 0);

    // Guard gap of 4: second start 5 cycles after the win_done cycle
    cfg_gap = 4;
    applyStimulus(1, 0, 0, 0);
    checkOutput("t2_start0", win_start_pulse, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t2_gap_c1", win_start_pulse, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t2_gap_c2", win_start_pulse, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t2_gap_c3", win_start_pulse, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t2_gap_c4", win_start_pulse, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t2_start1", win_start_pulse, 1);
    checkOutput("t2_idx1", slot_idx, 1);
    checkOutput("t2_nodone", frame_done, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t2_done", frame_done, 1);

    // Zero-slot frame completes immediately without a start
    cfg_nslot = 0; cfg_gap = 0;
    base = startCount;
    applyStimulus(1, 0, 0, 0);
    checkOutput("t3_zero_done", frame_done, 1);
    checkOutput("t3_zero_start", win_start_pulse, 0);
    checkOutput("t3_zero_busy", frame_busy, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t3_zero_count", startCount - base, 0);

    // nslot=7 clamps to the four-entry table
    cfgWrite(2, 7, 8);
    cfgWrite(3, 9, 10);
    cfg_nslot = 7;
    base = startCount;
    applyStimulus(1, 0, 0, 0);
    checkOutput("t3_idx0", slot_idx, 0);
    checkOutput("t3_delay0", win_delay, expDelay[0]);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1);
      checkOutput($sformatf("t3_start%0d", i), win_start_pulse, 1);
      checkOutput($sformatf("t3_idx%0d", i), slot_idx, i);
      checkOutput($sformatf("t3_delay%0d", i), win_delay, expDelay[i]);
    end
    applyStimulus(0, 0, 0, 1);
    checkOutput("t3_done", frame_done, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t3_count", startCount - base, 4);

    // Watchdog of 10 expires with no done
    cfgWrite(0, 0, 20);
    cfg_nslot = 1; cfg_wd = 10;
    applyStimulus(1, 0, 0, 0);
    checkOutput("t4_start", win_start_pulse, 1);
    repeat (9) applyStimulus(0, 0, 1, 0);
    checkOutput("t4_no_tmo_early", err_timeout, 0);
    checkOutput("t4_busy_early", frame_busy, 1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("t4_tmo", err_timeout, 1);
    checkOutput("t4_tmo_busy", frame_busy, 0);
    checkOutput("t4_tmo_nodone", frame_done, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("t4_tmo_pulse", err_timeout, 0);

    // Trigger while the window controller is still busy
    base = startCount;
    applyStimulus(1, 0, 1, 0);
    checkOutput("t4_ovr", trig_overrun, 1);
    checkOutput("t4_ovr_start", win_start_pulse, 0);
    checkOutput("t4_ovr_busy", frame_busy, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t4_ovr_pulse", trig_overrun, 0);
    checkOutput("t4_ovr_count", startCount - base, 0);

    // win_done coincident with watchdog expiry wins
    cfg_nslot = 2;
    applyStimulus(1, 0, 0, 0);
    repeat (9) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t4_coin_tmo", err_timeout, 0);
    checkOutput("t4_coin_start", win_start_pulse, 1);
    checkOutput("t4_coin_idx", slot_idx, 1);
    checkOutput("t4_coin_window", win_window, 2);
    repeat (3) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t4_coin_done", frame_done, 1);

    // Abort during the gap of a three-slot frame; trigger in WAIT overruns
    cfg_nslot = 3; cfg_gap = 4; cfg_wd = 0;
    base = startCount;
    applyStimulus(1, 0, 0, 0);
    checkOutput("t5_start", win_start_pulse, 1);
    applyStimulus(1, 0, 1, 0);
    checkOutput("t5_wait_ovr", trig_overrun, 1);
    checkOutput("t5_wait_nostart", win_start_pulse, 0);
    checkOutput("t5_wait_busy", frame_busy, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("t5_abort", frame_abort, 1);
    checkOutput("t5_abort_busy", frame_busy, 0);
    checkOutput("t5_abort_nodone", frame_done, 0);
    repeat (6) applyStimulus(0, 0, 0, 0);
    checkOutput("t5_abort_pulse", frame_abort, 0);
    checkOutput("t5_count", startCount - base, 1);
    applyStimulus(1, 1, 0, 0);
    checkOutput("t5_idle_abort_start", win_start_pulse, 0);
    checkOutput("t5_idle_abort_ovr", trig_overrun, 0);
    checkOutput("t5_idle_abort_busy", frame_busy, 0);

    // Table write on the slot-1 issue edge must not affect that issue
    cfg_nslot = 2; cfg_gap = 0;
    applyStimulus(1, 0, 0, 0);
    cfg_we = 1'b1; cfg_addr = 1; cfg_delay = 11; cfg_window = 12;
    applyStimulus(0, 0, 0, 1);
    cfg_we = 1'b0;
    checkOutput("t6_old_delay", win_delay, 0);
    checkOutput("t6_old_window", win_window, 2);
    checkOutput("t6_idx", slot_idx, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t6_done", frame_done, 1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t6_new_delay", win_delay, 11);
    checkOutput("t6_new_window", win_window, 12);
    applyStimulus(0, 0, 0, 1);

    // Asynchronous reset mid-WAIT clears outputs and the table
    cfg_nslot = 1;
    applyStimulus(1, 0, 0, 0);
    checkOutput("t6_pre_rst_window", win_window, 20);
    applyStimulus(0, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_busy", frame_busy, 0);
    checkOutput("t6_rst_window", win_window, 0);
    checkOutput("t6_rst_start", win_start_pulse, 0);
    #2 rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0);
    checkOutput("t6_post_start", win_start_pulse, 1);
    checkOutput("t6_post_delay", win_delay, 0);
    checkOutput("t6_post_window", win_window, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t6_post_done", frame_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_slot_sched.md
Name: rx_slot_sched

Overview:
- Frame-level scheduler that sequences the RX receive-window controller through a programmable table of up to 2**IDX_W receive slots per frame.
- Each slot has its own delay and window length.
- On each frame trigger the block issues one window start per slot, with its own delay/window values, and waits for that window's done pulse. It then inserts an optional guard gap and moves to the next slot.
- Sits between the frame timing logic (130M domain) and the window controller. Provides a per-slot watchdog, abort, and overrun detection.

Parameters:
- CNT_W, 32, width of delay/window/gap/watchdog counts in clk cycles.
- IDX_W, 2, slot index width; table depth NSLOT = 2**IDX_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- cfg_we  in  1  slot table write strobe.
- cfg_addr  in  IDX_W  slot table write address.
- cfg_delay  in  CNT_W  delay value written to table[cfg_addr].
- cfg_window  in  CNT_W  window value written to table[cfg_addr].
- cfg_nslot  in  IDX_W+1  active slots per frame; values above NSLOT are clamped to NSLOT.
- cfg_gap  in  CNT_W  guard cycles between a slot's done and the next slot's start.
- cfg_wd  in  CNT_W  per-slot watchdog limit in cycles; 0 disables the watchdog.
- frame_trig  in  1  1clk frame start pulse.
- abort  in  1  1clk abort request.
- win_busy  in  1  busy from window controller.
- win_done  in  1  1clk rx_done from window controller.
- win_start_pulse  out  1  1clk start to window controller.
- win_delay  out  CNT_W  delay for the current slot, held stable until the next issue.
- win_window  out  CNT_W  window length for the current slot, held stable until the next issue.
- slot_idx  out  IDX_W  index of the current/last issued slot.
- frame_busy  out  1  high from trigger acceptance until frame end.
- frame_done  out  1  1clk, all slots completed.
- frame_abort  out  1  1clk, frame terminated by abort.
- err_timeout  out  1  1clk, watchdog expired.
- trig_overrun  out  1  1clk, trigger rejected.

Behaviour:
- Reset: all outputs are 0; state is IDLE; counters are 0; all table entries are (0,0).
- All outputs are registered.
- Table write:
  - When cfg_we=1, table[cfg_addr] is written at the clock edge. Writes are allowed in any state.
  - The table is read on the issue edge. A write to the same address on that same edge does not affect the issue; the old value is used.
- Latched at acceptance: cfg_nslot (clamped), cfg_gap and cfg_wd are latched when a trigger is accepted. Changes during a frame have no effect on that frame.
- States: IDLE, WAIT, GAP.
- IDLE, frame_trig=1, abort=0, win_busy=0 (trigger accepted):
  - If latched nslot=0: frame_done=1 next cycle; state stays IDLE; no start is issued.
  - Otherwise: issue slot 0. On the next edge, win_start_pulse=1 with win_delay/win_window = table[0], slot_idx=0, frame_busy=1, and the state moves to WAIT.
- IDLE, frame_trig=1 with win_busy=1, or frame_trig=1 in WAIT/GAP: trig_overrun=1 for one cycle; the trigger is otherwise ignored.
- WAIT:
  - wd_cnt clears on the issue edge and then increments each cycle.
  - win_done=1 on the last slot (slot_idx == nslot-1): frame_done=1, frame_busy=0, state goes to IDLE.
  - win_done=1 on a non-last slot with gap=0: the next slot is issued on the same edge, so its start pulse appears the cycle after win_done.
  - win_done=1 on a non-last slot with gap>0: state goes to GAP with gap_cnt=0.
  - cfg_wd≠0, wd_cnt == wd-1, and win_done=0: err_timeout=1, frame_busy=0, state goes to IDLE.
  - win_done and watchdog expiry in the same cycle: win_done takes priority.
- GAP: gap_cnt increments each cycle. At gap_cnt == gap-1, slot_idx+1 is issued. The start pulse therefore appears gap+1 cycles after the win_done cycle.
- abort=1 in WAIT/GAP: highest priority over win_done, watchdog, gap expiry and frame_trig.
  - frame_abort=1, frame_busy=0, state goes to IDLE; no frame_done.
  - The downstream window already running is not stopped.
  - If frame_trig is also high on that edge, it raises trig_overrun.
- abort=1 in IDLE: ignored, and any frame_trig on the same cycle is also ignored.
- win_done in IDLE or GAP: ignored.
- Issued start pulses always equal the number of issues; at most one start per win_done.
- Reset asserted mid-frame: immediate return to reset values, including clearing the table.

Test Plan:
- table[0]=(3,5), table[1]=(0,2), nslot=2, gap=0, wd=0, real window ctrl attached, trig at cycle T -> start at T+1 (3,5); second start the cycle after first win_done (0,2); frame_done the cycle after second win_done; frame_busy high T+1 through that cycle.
- Same table with gap=4 -> second start exactly 5 cycles after first win_done cycle; slot_idx=1.
- nslot=0 -> frame_done at T+1, no start pulse. nslot=7 (IDX_W=2) -> exactly 4 starts, slot_idx 0..3, then frame_done.
- wd=10, table[0]=(0,20) -> err_timeout 10 cycles after issue edge, IDLE, no frame_done. Then trig while win_busy=1 -> trig_overrun, no start. Also drive win_done coincident with expiry -> no err_timeout, frame proceeds.
- abort during GAP of a 3-slot frame -> frame_abort one cycle later, no further starts, no frame_done. Trig during WAIT -> trig_overrun only.
- Write table[1] on the edge slot 1 issues -> old value used. Assert rst_n=0 mid-WAIT -> all outputs 0 asynchronously; after release, trig with nslot=1 issues (0,0).
